// File: rtl/apb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_pkg : shared types and widths for the APB completer slice        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package apb_pkg;

  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_STRB_W     = APB_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_MISALIGNED = 2'd1,
    ERR_RANGE      = 2'd2,
    ERR_PROTOCOL   = 2'd3
  } apb_err_cause_e;

endpackage
`default_nettype wire

// File: rtl/apb_completer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_completer_if : APB bus bundle between bridge and completer       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface apb_completer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_regfile : word register file, byte-strobe write, sync read       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module apb_regfile
  import apb_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      i_wr_en,
  input  logic                      i_rd_en,
  input  logic [IDX_W-1:0]          i_idx,
  input  logic [APB_DATA_WIDTH-1:0] i_wr_data,
  input  logic [APB_STRB_W-1:0]     i_wr_strb,
  output logic [APB_DATA_WIDTH-1:0] o_rd_data
);

  logic [APB_DATA_WIDTH-1:0] r_mem [NUM_REGS];
  logic [APB_DATA_WIDTH-1:0] r_rd_data;

  // Read data is zero whenever no read completes, so the bus sees 0 outside RESP.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
      r_rd_data <= '0;
    end else begin
      if (i_wr_en) begin
        for (int b = 0; b < APB_STRB_W; b++) begin
          if (i_wr_strb[b]) r_mem[i_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
        end
      end
      r_rd_data <= i_rd_en ? r_mem[i_idx] : '0;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/apb_completer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_completer : APB peripheral with register file and wait states    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module apb_completer
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic           pclk,
  input  logic           presetn,
  apb_completer_if.slave bus
);

  localparam int c_idx_w = $clog2(NUM_REGS);
  localparam int c_cnt_w = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_wait_max = c_cnt_w'(WAIT_STATES);

  apb_state_e              r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [APB_STRB_W-1:0]   r_strb;
  logic [c_cnt_w-1:0]      r_cnt;
  logic                    r_pready;
  logic                    r_pslverr;

  logic                    w_idle_err;
  logic                    w_violation;
  logic                    w_cnt_done;
  logic                    w_to_resp;
  logic                    w_commit_wr;
  logic                    w_commit_rd;
  logic [DATA_WIDTH-1:0]   w_rd_data;
  apb_err_cause_e          w_err_cause;

  assign w_idle_err  = (r_state == IDLE) && bus.psel && bus.penable;
  assign w_violation = (r_state == ACCESS) &&
                       (!bus.psel || !bus.penable ||
                        (bus.paddr != r_addr) || (bus.pwrite != r_write));
  assign w_cnt_done  = (r_cnt == c_wait_max);
  assign w_to_resp   = w_idle_err || ((r_state == ACCESS) && (w_violation || w_cnt_done));

  // Protocol faults win over address faults, which are judged on the latched address.
  always_comb begin
    w_err_cause = ERR_NONE;
    if (w_idle_err || w_violation)            w_err_cause = ERR_PROTOCOL;
    else if (|r_addr[1:0])                    w_err_cause = ERR_MISALIGNED;
    else if (|r_addr[ADDR_WIDTH-1:2+c_idx_w]) w_err_cause = ERR_RANGE;
  end

  assign w_commit_wr = w_to_resp && (w_err_cause == ERR_NONE) &&  r_write;
  assign w_commit_rd = w_to_resp && (w_err_cause == ERR_NONE) && !r_write;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_cnt     <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_pready  <= w_to_resp;
      r_pslverr <= w_to_resp && (w_err_cause != ERR_NONE);
      case (r_state)
        IDLE: begin
          if (bus.psel && !bus.penable) begin
            r_state <= SETUP;
            r_addr  <= bus.paddr;
            r_write <= bus.pwrite;
            r_wdata <= bus.pwdata;
            r_strb  <= bus.pstrb;
            r_cnt   <= '0;
          end else if (w_idle_err) begin
            r_state <= RESP;
          end
        end
        SETUP:  r_state <= ACCESS;
        ACCESS: begin
          if (w_to_resp)         r_state <= RESP;
          else if (!w_cnt_done)  r_cnt   <= r_cnt + 1'b1;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  apb_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (c_idx_w)
  ) u_regfile (
    .pclk      (pclk),
    .presetn   (presetn),
    .i_wr_en   (w_commit_wr),
    .i_rd_en   (w_commit_rd),
    .i_idx     (r_addr[2 +: c_idx_w]),
    .i_wr_data (r_wdata),
    .i_wr_strb (r_strb),
    .o_rd_data (w_rd_data)
  );

  assign bus.pready  = r_pready;
  assign bus.pslverr = r_pslverr;
  assign bus.prdata  = w_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_apb_completer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_apb_completer : directed bench for apb_completer (0/1/3 waits)    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_apb_completer;

  logic        pclk;
  logic        presetn;
  logic        drv_psel;
  logic        drv_penable;
  logic        drv_pwrite;
  logic [31:0] drv_paddr;
  logic [31:0] drv_pwdata;
  logic [3:0]  drv_pstrb;

  int          sel;
  logic        obs_pready;
  logic        obs_pslverr;
  logic [31:0] obs_prdata;

  int n_vec = 0;
  int n_err = 0;

  apb_completer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  apb_completer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
  apb_completer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

  assign bus0.psel = drv_psel;   assign bus0.penable = drv_penable; assign bus0.pwrite = drv_pwrite;
  assign bus0.paddr = drv_paddr; assign bus0.pwdata = drv_pwdata;   assign bus0.pstrb = drv_pstrb;
  assign bus1.psel = drv_psel;   assign bus1.penable = drv_penable; assign bus1.pwrite = drv_pwrite;
  assign bus1.paddr = drv_paddr; assign bus1.pwdata = drv_pwdata;   assign bus1.pstrb = drv_pstrb;
  assign bus3.psel = drv_psel;   assign bus3.penable = drv_penable; assign bus3.pwrite = drv_pwrite;
  assign bus3.paddr = drv_paddr; assign bus3.pwdata = drv_pwdata;   assign bus3.pstrb = drv_pstrb;

  apb_completer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(0))
    u_dut0 (.pclk(pclk), .presetn(presetn), .bus(bus0));
  apb_completer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(1))
    u_dut1 (.pclk(pclk), .presetn(presetn), .bus(bus1));
  apb_completer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(3))
    u_dut3 (.pclk(pclk), .presetn(presetn), .bus(bus3));

  always_comb begin
    obs_pready  = bus1.pready;
    obs_pslverr = bus1.pslverr;
    obs_prdata  = bus1.prdata;
    if (sel == 0) begin
      obs_pready  = bus0.pready;
      obs_pslverr = bus0.pslverr;
      obs_prdata  = bus0.prdata;
    end else if (sel == 3) begin
      obs_pready  = bus3.pready;
      obs_pslverr = bus3.pslverr;
      obs_prdata  = bus3.prdata;
    end
  end

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete transfer as the bridge would issue it; returns the response and wait count.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic err, output int waits);
    int n;
    drv_psel = 1'b1; drv_penable = 1'b0; drv_pwrite = wr;
    drv_paddr = addr; drv_pwdata = wdata; drv_pstrb = strb;
    @(posedge pclk); #1;
    drv_penable = 1'b1;
    n = 0;
    while (!obs_pready && n < 20) begin
      @(posedge pclk); #1;
      n++;
    end
    check_eq("pready_seen", {31'd0, obs_pready}, 32'd1);
    rdata = obs_prdata;
    err   = obs_pslverr;
    waits = n - 2;
    @(posedge pclk); #1;
    drv_psel = 1'b0; drv_penable = 1'b0;
    check_eq("pready_one_cycle", {31'd0, obs_pready}, 32'd0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic exp_err, input int exp_waits);
    logic [31:0] rd;
    logic        err;
    int          w;
    apb_xfer(1'b1, addr, data, strb, rd, err, w);
    check_eq("wr_pslverr", {31'd0, err}, {31'd0, exp_err});
    check_eq("wr_prdata_zero", rd, 32'd0);
    check_eq("wr_waits", 32'(w), 32'(exp_waits));
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic exp_err, input int exp_waits);
    logic [31:0] rd;
    logic        err;
    int          w;
    apb_xfer(1'b0, addr, 32'hFFFF_FFFF, 4'h0, rd, err, w);
    check_eq("rd_data", rd, exp_data);
    check_eq("rd_pslverr", {31'd0, err}, {31'd0, exp_err});
    check_eq("rd_waits", 32'(w), 32'(exp_waits));
  endtask

  task automatic do_reset();
    presetn = 1'b0;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    presetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_reg;
    presetn = 1'b0;
    drv_psel = 1'b0; drv_penable = 1'b0; drv_pwrite = 1'b0;
    drv_paddr = '0; drv_pwdata = '0; drv_pstrb = '0;
    sel = 1;
    repeat (3) @(posedge pclk);
    #1;
    check_eq("reset_pready", {31'd0, obs_pready}, 32'd0);
    check_eq("reset_pslverr", {31'd0, obs_pslverr}, 32'd0);
    check_eq("reset_prdata", obs_prdata, 32'd0);
    presetn = 1'b1;
    @(posedge pclk); #1;

    // One wait state: basic, partial-strobe and error traffic.
    do_write(32'h4, 32'hDEAD_BEEF, 4'hF, 1'b0, 1);
    do_read (32'h4, 32'hDEAD_BEEF, 1'b0, 1);
    do_write(32'h8, 32'hAABB_CCDD, 4'hF, 1'b0, 1);
    do_write(32'h8, 32'h1122_3344, 4'h5, 1'b0, 1);
    do_read (32'h8, 32'hAA22_CC44, 1'b0, 1);
    do_write(32'h8, 32'hFFFF_FFFF, 4'h0, 1'b0, 1);
    do_read (32'h8, 32'hAA22_CC44, 1'b0, 1);
    do_read (32'h3, 32'h0, 1'b1, 1);
    do_write(32'h6, 32'hFFFF_FFFF, 4'hF, 1'b1, 1);
    do_read (32'h4, 32'hDEAD_BEEF, 1'b0, 1);
    do_write(32'h3C, 32'h0BAD_F00D, 4'hF, 1'b0, 1);
    do_write(32'h40, 32'h5555_5555, 4'hF, 1'b1, 1);
    do_read (32'h44, 32'h0, 1'b1, 1);
    for (int i = 0; i < 16; i++) begin
      exp_reg = (i == 1)  ? 32'hDEAD_BEEF :
                (i == 2)  ? 32'hAA22_CC44 :
                (i == 15) ? 32'h0BAD_F00D : 32'h0;
      do_read(32'(i * 4), exp_reg, 1'b0, 1);
    end

    // Access phase without a setup phase.
    drv_psel = 1'b1; drv_penable = 1'b1; drv_pwrite = 1'b0; drv_paddr = 32'h4;
    @(posedge pclk); #1;
    check_eq("nosetup_pready", {31'd0, obs_pready}, 32'd1);
    check_eq("nosetup_pslverr", {31'd0, obs_pslverr}, 32'd1);
    check_eq("nosetup_prdata", obs_prdata, 32'd0);
    drv_psel = 1'b0; drv_penable = 1'b0;
    @(posedge pclk); #1;
    check_eq("nosetup_pready_drop", {31'd0, obs_pready}, 32'd0);

    // Reset in the middle of a write's access phase.
    drv_psel = 1'b1; drv_penable = 1'b0; drv_pwrite = 1'b1;
    drv_paddr = 32'hC; drv_pwdata = 32'hFFFF_FFFF; drv_pstrb = 4'hF;
    @(posedge pclk); #1;
    drv_penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    check_eq("midrst_pre_pready", {31'd0, obs_pready}, 32'd0);
    presetn = 1'b0;
    #1;
    check_eq("midrst_pready", {31'd0, obs_pready}, 32'd0);
    check_eq("midrst_pslverr", {31'd0, obs_pslverr}, 32'd0);
    check_eq("midrst_prdata", obs_prdata, 32'd0);
    drv_psel = 1'b0; drv_penable = 1'b0;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    check_eq("midrst_hold_pready", {31'd0, obs_pready}, 32'd0);
    presetn = 1'b1;
    @(posedge pclk); #1;
    do_read(32'hC, 32'h0, 1'b0, 1);
    do_read(32'h4, 32'h0, 1'b0, 1);

    // Three wait states: psel dropped in the second access cycle.
    do_reset();
    sel = 3;
    do_write(32'h4, 32'hCAFE_F00D, 4'hF, 1'b0, 3);
    drv_psel = 1'b1; drv_penable = 1'b0; drv_pwrite = 1'b1;
    drv_paddr = 32'h4; drv_pwdata = 32'h0123_4567; drv_pstrb = 4'hF;
    @(posedge pclk); #1;
    drv_penable = 1'b1;
    @(posedge pclk); #1;
    check_eq("viol_pready_early", {31'd0, obs_pready}, 32'd0);
    drv_psel = 1'b0;
    @(posedge pclk); #1;
    check_eq("viol_pready", {31'd0, obs_pready}, 32'd1);
    check_eq("viol_pslverr", {31'd0, obs_pslverr}, 32'd1);
    check_eq("viol_prdata", obs_prdata, 32'd0);
    drv_penable = 1'b0;
    @(posedge pclk); #1;
    check_eq("viol_pready_drop", {31'd0, obs_pready}, 32'd0);
    check_eq("viol_pslverr_drop", {31'd0, obs_pslverr}, 32'd0);
    do_read(32'h4, 32'hCAFE_F00D, 1'b0, 3);

    // Zero wait states, back-to-back.
    do_reset();
    sel = 0;
    do_write(32'h0, 32'h1234_5678, 4'hF, 1'b0, 0);
    do_write(32'h4, 32'h9ABC_DEF0, 4'hF, 1'b0, 0);
    do_read (32'h0, 32'h1234_5678, 1'b0, 0);
    do_read (32'h4, 32'h9ABC_DEF0, 1'b0, 0);
    do_read (32'h0, 32'h1234_5678, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
